uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, max idle cycles inside a locked packet (1..255).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester byte valid.
REQ-006 SHALL have port req_data, input, NUM_REQ*9, per-requester data; bit 8 is the 9th data bit, slot i at [9i+8:9i].
REQ-007 SHALL have port req_last, input, NUM_REQ, marks the final byte of a packet.
REQ-008 SHALL have port req_ready, output, NUM_REQ, byte accepted from requester i when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port tx_valid, output, 1, byte offered to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 9, byte to UART; bit 8 drives txDataBit9.
REQ-011 SHALL have port tx_ready, input, 1, UART accepts the byte this cycle.
REQ-012 SHALL have port tx_idle, input, 1, UART txIdle status bit.
REQ-013 SHALL have port grant_id, output, 3, index of the current owner; valid while busy.
REQ-014 SHALL have port busy, output, 1, high while a grant is held.
REQ-015 SHALL have port timeout_err, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-016 SHALL implement states IDLE, SEND and DRAIN.
REQ-017 IDLE: when any req_valid is high, SHALL latch the winner into grant_id and go to SEND on the next edge; this gives a one-cycle arbitration bubble.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first after reset.
REQ-019 SEND: tx_valid SHALL equal req_valid[grant_id] combinationally, and tx_data SHALL equal req_data slot grant_id.
REQ-020 SEND: req_ready[grant_id] SHALL equal tx_ready; all other req_ready bits SHALL be 0.
REQ-021 In IDLE and DRAIN, tx_valid and all req_ready bits SHALL be 0.
REQ-022 SEND: an accepted beat with req_last=1 SHALL move the block to DRAIN and set last_grant to grant_id.
REQ-023 The grant SHALL be held across non-last beats (packet atomicity); no other requester may be served mid-packet.
REQ-024 DRAIN: the block SHALL return to IDLE on the first cycle tx_idle=1; busy SHALL drop in that same transition.
REQ-025 The 8-bit idle counter SHALL clear on every accepted beat and on entry to SEND.
REQ-026 The idle counter SHALL increment each SEND cycle with req_valid[grant_id]=0, saturating at TIMEOUT.
REQ-027 When the counter reaches TIMEOUT, the block SHALL pulse timeout_err for one cycle, set last_grant to grant_id, and go to DRAIN.
REQ-028 Cycles with valid high and tx_ready low SHALL NOT count toward timeout; UART backpressure is unbounded.
REQ-029 busy SHALL be 1 in SEND and DRAIN, and 0 in IDLE.
REQ-030 A requester deasserting req_valid before its turn SHALL simply lose that arbitration; no state is retained for it.
REQ-031 A requester's req_valid arriving in the same cycle as another's last beat SHALL be considered at the next IDLE evaluation only.

Reset
REQ-032 reset_n low SHALL asynchronously force: state=IDLE, grant_id=0, last_grant=NUM_REQ-1, idle counter=0, busy=0, timeout_err=0, tx_valid=0, req_ready=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no further beats forwarded; the requester is responsible for resending.
REQ-034 Reset deassertion SHALL be synchronized externally; the first arbitration SHALL occur no earlier than the first edge after release.

Verification
REQ-035 Bench SHALL cover: after reset, req_valid=4'b1111 with single-byte packets -> grants in order 0,1,2,3,0; one idle bubble precedes each grant.
REQ-036 Bench SHALL cover: requester 2 sends 3-byte packet 0x101,0x055,0x0AA (last on third), with requester 0 valid throughout -> tx_data shows exactly those 3 bytes contiguously, then DRAIN, then grant 3 (if valid) else 0.
REQ-037 Bench SHALL cover: tx_ready held low 1000 cycles with valid high -> no timeout_err; data stable; beat completes when tx_ready rises.
REQ-038 Bench SHALL cover: grant 1 drops req_valid after first beat, TIMEOUT=8 -> timeout_err pulses 8 cycles later, busy falls once tx_idle=1, next grant goes to requester 2 (if valid).
REQ-039 Bench SHALL cover: reset_n pulsed low during SEND -> outputs take reset values immediately without a clock edge; first post-reset grant goes to requester 0.
REQ-040 Bench SHALL cover: tx_idle held 0 for 20 cycles after a last beat -> busy stays 1 and no req_ready for 20 cycles; IDLE is reached the cycle after tx_idle=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that gives one of NUM_REQ requesters
// exclusive access to a 9-bit UART transmitter for a whole packet. A grant
// is held until the packet's last beat is accepted (or the owner stalls for
// TIMEOUT cycles), then the block waits for the UART to report idle before
// arbitrating again.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*9-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [8:0]             tx_data,
  input  logic                   tx_ready,
  input  logic                   tx_idle,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LAST_RESET = 3'(NUM_REQ - 1);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       timeout_err_q, timeout_err_d;

  // Requester signals padded to the full 3-bit grant range so that indexing
  // by grant_q never goes out of bounds for any NUM_REQ.
  logic [7:0] valid_ext;
  logic [7:0] last_ext;
  logic [8:0] slot_data [8];
  logic [7:0] ready_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NUM_REQ) begin : g_used
        assign valid_ext[gi] = req_valid[gi];
        assign last_ext[gi]  = req_last[gi];
        assign slot_data[gi] = req_data[9*gi +: 9];
      end else begin : g_pad
        assign valid_ext[gi] = 1'b0;
        assign last_ext[gi]  = 1'b0;
        assign slot_data[gi] = 9'd0;
      end
    end
  endgenerate

  logic       any_valid;
  logic [2:0] winner;
  logic       sel_valid;
  logic       sel_last;
  logic       accept;

  assign any_valid = |req_valid;
  assign sel_valid = valid_ext[grant_q];
  assign sel_last  = last_ext[grant_q];
  assign accept    = (state_q == ST_SEND) && sel_valid && tx_ready;

  // Round-robin pick: scan from last_grant+1 upward (wrapping); scanning the
  // offsets from farthest to nearest lets the nearest valid requester win.
  always_comb begin
    int idx;
    idx    = 0;
    winner = last_grant_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (valid_ext[idx[2:0]]) begin
        winner = idx[2:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, round-robin pointer, idle counter and timeout pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q       <= 3'd0;
      last_grant_q  <= LAST_RESET;
      idle_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath-update logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d    = winner;
          idle_cnt_d = 8'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          idle_cnt_d = 8'd0;
          if (sel_last) begin
            last_grant_d = grant_q;
            state_d      = ST_DRAIN;
          end
        end else if (!sel_valid) begin
          // Only cycles where the owner offers nothing count; a stalled UART
          // with valid data waiting never revokes the grant.
          if (idle_cnt_q >= TIMEOUT_C - 8'd1) begin
            idle_cnt_d    = TIMEOUT_C;
            timeout_err_d = 1'b1;
            last_grant_d  = grant_q;
            state_d       = ST_DRAIN;
          end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (tx_idle) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: only the owner is connected to the UART, and only while sending.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 9'd0;
    ready_ext = 8'd0;
    if (state_q == ST_SEND) begin
      tx_valid           = sel_valid;
      tx_data            = slot_data[grant_q];
      ready_ext[grant_q] = tx_ready;
    end
  end

  assign req_ready   = ready_ext[NUM_REQ-1:0];
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*9-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [8:0]     tx_data;
  logic           tx_ready;
  logic           tx_idle;
  logic [2:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_idle    (tx_idle),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Requester sources: one FIFO of {last, data} per requester.
  logic [9:0] src_mem [N][64];
  int         src_rd [N];
  int         src_wr [N];
  bit         gap [N];

  task automatic push(input int r, input logic [8:0] d, input bit l);
    src_mem[r][src_wr[r][5:0]] = {l, d};
    src_wr[r]++;
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) push(r, 9'($urandom_range(0, 511)), j == len - 1);
  endtask

  task automatic drive_inputs();
    logic [9:0] head;
    for (int i = 0; i < N; i++) begin
      head = (src_wr[i] != src_rd[i]) ? src_mem[i][src_rd[i][5:0]] : 10'd0;
      req_valid[i]       = (src_wr[i] != src_rd[i]) && !gap[i];
      req_data[9*i +: 9] = head[8:0];
      req_last[i]        = head[9];
    end
  endtask

  // Reference model: who owns the UART, whether the owner may still send,
  // how long the owner has been silent, and the pending timeout pulse.
  bit m_busy, m_send, m_terr;
  int m_owner, m_last, m_idle;

  task automatic model_reset();
    m_busy = 0; m_send = 0; m_terr = 0;
    m_owner = 0; m_last = N - 1; m_idle = 0;
  endtask

  // Observations of DUT activity for scenario checks.
  int         step_no = 0;
  bit         prev_busy = 0;
  int         dut_grants[$];
  logic [8:0] dut_beats[$];
  int         beat_steps[$];
  int         terr_steps[$];

  task automatic clear_logs();
    dut_grants.delete(); dut_beats.delete(); beat_steps.delete(); terr_steps.delete();
  endtask

  task automatic step();
    logic [N-1:0] exp_ready;
    logic [N-1:0] pop_mask;
    logic [9:0]   head;
    logic         exp_txv;
    bit           terr_n;
    bit           found;
    int           c;
    drive_inputs();
    #1;
    exp_ready = '0;
    exp_txv   = 1'b0;
    if (m_send) begin
      exp_txv            = req_valid[m_owner];
      exp_ready[m_owner] = tx_ready;
    end
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
    check_val("tx_valid", 32'(tx_valid), 32'(exp_txv));
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_busy) check_val("grant_id", 32'(grant_id), 32'(m_owner));
    if (m_send && req_valid[m_owner]) begin
      head = src_mem[m_owner][src_rd[m_owner][5:0]];
      check_val("tx_data", 32'(tx_data), 32'(head[8:0]));
    end
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
    prev_busy = busy;
    if (tx_valid && tx_ready) begin
      dut_beats.push_back(tx_data);
      beat_steps.push_back(step_no);
    end
    if (timeout_err) terr_steps.push_back(step_no);
    pop_mask = req_valid & req_ready;
    @(posedge clk);
    terr_n = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req_valid[c]) begin
          found = 1; m_owner = c;
        end
      end
      if (found) begin
        m_busy = 1; m_send = 1; m_idle = 0;
      end
    end else if (m_send) begin
      if (req_valid[m_owner] && tx_ready) begin
        m_idle = 0;
        if (req_last[m_owner]) begin
          m_send = 0; m_last = m_owner;
        end
      end else if (!req_valid[m_owner]) begin
        m_idle = m_idle + 1;
        if (m_idle >= T) begin
          m_idle = T; terr_n = 1; m_send = 0; m_last = m_owner;
        end
      end
    end else if (tx_idle) begin
      m_busy = 0;
    end
    m_terr = terr_n;
    for (int i = 0; i < N; i++) if (pop_mask[i]) src_rd[i]++;
    step_no++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += src_wr[i] - src_rd[i];
    return s;
  endfunction

  int cnt;

  initial begin
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    tx_idle  = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0; src_wr[i] = 0; gap[i] = 0;
    end
    drive_inputs();
    model_reset();
    #2;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_grant_id", 32'(grant_id), 32'd0);
    check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // All four requesters valid with single-byte packets.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      push(i, 9'(16 + i), 1'b1);
      push(i, 9'(32 + i), 1'b1);
    end
    run(24);
    check_val("rr_count", 32'(dut_grants.size()), 32'd8);
    if (dut_grants.size() >= 5) begin
      check_val("rr_g0", 32'(dut_grants[0]), 32'd0);
      check_val("rr_g1", 32'(dut_grants[1]), 32'd1);
      check_val("rr_g2", 32'(dut_grants[2]), 32'd2);
      check_val("rr_g3", 32'(dut_grants[3]), 32'd3);
      check_val("rr_g4", 32'(dut_grants[4]), 32'd0);
    end
    if (beat_steps.size() >= 2) check_val("rr_spacing", 32'(beat_steps[1] - beat_steps[0]), 32'd3);

    // Move the pointer to 1, then a 3-byte packet from 2 with 0 also waiting.
    push(1, 9'h0F1, 1'b1);
    run(4);
    clear_logs();
    push(2, 9'h101, 1'b0);
    push(2, 9'h055, 1'b0);
    push(2, 9'h0AA, 1'b1);
    push(0, 9'h033, 1'b1);
    run(10);
    check_val("pkt_beats", 32'(dut_beats.size()), 32'd4);
    if (dut_beats.size() >= 4) begin
      check_val("pkt_b0", 32'(dut_beats[0]), 32'h101);
      check_val("pkt_b1", 32'(dut_beats[1]), 32'h055);
      check_val("pkt_b2", 32'(dut_beats[2]), 32'h0AA);
      check_val("pkt_contig", 32'(beat_steps[2] - beat_steps[0]), 32'd2);
      check_val("pkt_next", 32'(dut_beats[3]), 32'h033);
    end
    if (dut_grants.size() >= 2) begin
      check_val("pkt_grant_a", 32'(dut_grants[0]), 32'd2);
      check_val("pkt_grant_b", 32'(dut_grants[1]), 32'd0);
    end

    // Long UART backpressure with valid held high.
    clear_logs();
    tx_ready = 1'b0;
    push(0, 9'h1C3, 1'b1);
    run(1000);
    check_val("bp_no_timeout", 32'(terr_steps.size()), 32'd0);
    check_val("bp_no_beat", 32'(dut_beats.size()), 32'd0);
    tx_ready = 1'b1;
    run(4);
    check_val("bp_beat_count", 32'(dut_beats.size()), 32'd1);
    if (dut_beats.size() >= 1) check_val("bp_beat_data", 32'(dut_beats[0]), 32'h1C3);

    // Owner 1 stalls after its first beat; requester 2 waits.
    clear_logs();
    tx_idle = 1'b0;
    push(1, 9'h011, 1'b0);
    push(2, 9'h122, 1'b1);
    run(14);
    check_val("to_pulses", 32'(terr_steps.size()), 32'd1);
    if (terr_steps.size() >= 1 && beat_steps.size() >= 1)
      check_val("to_latency", 32'(terr_steps[0] - beat_steps[0] - 1), 32'(T));
    check_val("to_busy_held", 32'(busy), 32'd1);
    tx_idle = 1'b1;
    run(6);
    if (dut_grants.size() >= 2) check_val("to_next_grant", 32'(dut_grants[1]), 32'd2);
    else check_val("to_grant_count", 32'(dut_grants.size()), 32'd2);

    // UART stays busy for 20 cycles after a last beat.
    clear_logs();
    tx_idle = 1'b0;
    push(3, 9'h1F0, 1'b1);
    run(2);
    push(0, 9'h077, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy && req_ready == '0 && !tx_valid) cnt++;
    end
    check_val("drain_hold", 32'(cnt), 32'd20);
    tx_idle = 1'b1;
    step();
    #1 check_val("drain_exit", 32'(busy), 32'd0);
    run(4);
    check_val("drain_beats", 32'(dut_beats.size()), 32'd2);

    // Reset pulsed while a packet is in flight.
    clear_logs();
    tx_ready = 1'b0;
    push(1, 9'h0C1, 1'b1);
    push(2, 9'h0D2, 1'b0);
    push(2, 9'h0D3, 1'b1);
    run(3);
    check_val("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_mid_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_mid_grant", 32'(grant_id), 32'd0);
    check_val("rst_mid_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0; src_wr[i] = 0;
    end
    model_reset();
    prev_busy = 0;
    clear_logs();
    tx_ready = 1'b1;
    reset_n  = 1'b1;
    push(2, 9'h0E2, 1'b1);
    push(0, 9'h0E0, 1'b1);
    run(8);
    if (dut_grants.size() >= 1) check_val("rst_first_grant", 32'(dut_grants[0]), 32'd0);
    else check_val("rst_grant_count", 32'(dut_grants.size()), 32'd2);

    // Randomized traffic, UART backpressure and idle, and valid gaps.
    for (int s = 0; s < 2500; s++) begin
      if ($urandom_range(0, 5) == 0) begin
        cnt = int'($urandom_range(0, N - 1));
        if (src_wr[cnt] - src_rd[cnt] < 56) push_pkt(cnt, int'($urandom_range(1, 4)));
      end
      for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 7) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      tx_idle  = ($urandom_range(0, 2) != 0);
      step();
    end
    for (int i = 0; i < N; i++) gap[i] = 0;
    tx_ready = 1'b1;
    tx_idle  = 1'b1;
    run(300);
    check_val("rand_drained", 32'(pending()), 32'd0);
    check_val("rand_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
